// File: rtl/slot_reel_controller.sv
// Three-reel slot machine spin engine: steps decimal reel digits on a divided tick,
// stops reels one at a time on stop pulses, scores the final pattern and keeps a credit balance.
module slot_reel_controller #(
    parameter int unsigned SPIN_DIV      = 2_500_000,
    parameter int unsigned INIT_CREDITS  = 10,
    parameter int unsigned PAIR_PAYOUT   = 2,
    parameter int unsigned TRIPLE_PAYOUT = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] reel0,
    output logic [3:0] reel1,
    output logic [3:0] reel2,
    output logic [6:0] credits,
    output logic [1:0] win,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SPIN3 = 3'd1,
        ST_SPIN2 = 3'd2,
        ST_SPIN1 = 3'd3,
        ST_SCORE = 3'd4
    } state_t;

    localparam logic [23:0] TICK_LAST    = 24'(SPIN_DIV - 1);
    localparam logic [6:0]  CREDITS_INIT = 7'(INIT_CREDITS);
    localparam logic [7:0]  PAIR_AMT     = 8'(PAIR_PAYOUT);
    localparam logic [7:0]  TRIPLE_AMT   = 8'(TRIPLE_PAYOUT);

    // Advance a decimal digit by a fixed step, staying within 0..9.
    function automatic logic [3:0] reel_advance(input logic [3:0] cur, input logic [3:0] step);
        logic [4:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (sum >= 5'd10) begin
            reel_advance = 4'(sum - 5'd10);
        end else begin
            reel_advance = sum[3:0];
        end
    endfunction

    // Classify the frozen reels: 2 triple, 1 exactly one pair, 0 none.
    function automatic logic [1:0] score_reels(input logic [3:0] a, input logic [3:0] b,
                                               input logic [3:0] c);
        if ((a == b) && (b == c)) begin
            score_reels = 2'd2;
        end else if ((a == b) || (b == c) || (a == c)) begin
            score_reels = 2'd1;
        end else begin
            score_reels = 2'd0;
        end
    endfunction

    state_t      state_r, state_nxt_s;
    logic [23:0] cnt_r, cnt_nxt_s;
    logic [3:0]  reel0_r, reel1_r, reel2_r;
    logic [3:0]  reel0_nxt_s, reel1_nxt_s, reel2_nxt_s;
    logic [6:0]  credits_r, credits_nxt_s;
    logic [1:0]  win_r, win_nxt_s, win_calc_s;
    logic        busy_r, busy_nxt_s, done_r, done_nxt_s;
    logic        tick_s;
    logic [7:0]  payout_s, credit_sum_s;

    assign tick_s = ((state_r == ST_SPIN3) || (state_r == ST_SPIN2) || (state_r == ST_SPIN1))
                    && (cnt_r == TICK_LAST);
    assign win_calc_s   = score_reels(reel0_r, reel1_r, reel2_r);
    assign credit_sum_s = {1'b0, credits_r} + payout_s;

    // Payout selected by the score of the frozen reels.
    always_comb begin
        payout_s = 8'd0;
        case (win_calc_s)
            2'd2:    payout_s = TRIPLE_AMT;
            2'd1:    payout_s = PAIR_AMT;
            default: payout_s = 8'd0;
        endcase
    end

    // Next-state and datapath update; a reel being stopped never takes a coincident tick.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        reel0_nxt_s   = reel0_r;
        reel1_nxt_s   = reel1_r;
        reel2_nxt_s   = reel2_r;
        credits_nxt_s = credits_r;
        win_nxt_s     = win_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 24'd0;
                if (start && (credits_r != 7'd0)) begin
                    state_nxt_s   = ST_SPIN3;
                    credits_nxt_s = credits_r - 7'd1;
                    win_nxt_s     = 2'd0;
                    busy_nxt_s    = 1'b1;
                end else begin
                    busy_nxt_s    = 1'b0;
                end
            end
            ST_SPIN3, ST_SPIN2, ST_SPIN1: begin
                cnt_nxt_s = tick_s ? 24'd0 : (cnt_r + 24'd1);
                if (tick_s && (state_r == ST_SPIN3) && !stop) begin
                    reel0_nxt_s = reel_advance(reel0_r, 4'd1);
                end else begin
                    reel0_nxt_s = reel0_r;
                end
                if (tick_s && ((state_r == ST_SPIN3) || ((state_r == ST_SPIN2) && !stop))) begin
                    reel1_nxt_s = reel_advance(reel1_r, 4'd3);
                end else begin
                    reel1_nxt_s = reel1_r;
                end
                if (tick_s && !((state_r == ST_SPIN1) && stop)) begin
                    reel2_nxt_s = reel_advance(reel2_r, 4'd7);
                end else begin
                    reel2_nxt_s = reel2_r;
                end
                if (stop) begin
                    case (state_r)
                        ST_SPIN3: state_nxt_s = ST_SPIN2;
                        ST_SPIN2: state_nxt_s = ST_SPIN1;
                        default:  state_nxt_s = ST_SCORE;
                    endcase
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_SCORE: begin
                state_nxt_s   = ST_IDLE;
                cnt_nxt_s     = 24'd0;
                win_nxt_s     = win_calc_s;
                credits_nxt_s = (credit_sum_s > 8'd99) ? 7'd99 : credit_sum_s[6:0];
                done_nxt_s    = 1'b1;
                busy_nxt_s    = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 24'd0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 24'd0;
            reel0_r   <= 4'd0;
            reel1_r   <= 4'd0;
            reel2_r   <= 4'd0;
            credits_r <= CREDITS_INIT;
            win_r     <= 2'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            reel0_r   <= reel0_nxt_s;
            reel1_r   <= reel1_nxt_s;
            reel2_r   <= reel2_nxt_s;
            credits_r <= credits_nxt_s;
            win_r     <= win_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign reel0   = reel0_r;
    assign reel1   = reel1_r;
    assign reel2   = reel2_r;
    assign credits = credits_r;
    assign win     = win_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_slot_reel_controller.sv
// Directed bench for slot_reel_controller (SPIN_DIV=4) with extra instances for the
// saturating-credit and zero-credit boundaries.
module tb_slot_reel_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0;
    logic start_hi = 1'b0, stop_hi = 1'b0;
    logic start_z = 1'b0, stop_z = 1'b0;

    logic [3:0] reel0, reel1, reel2, reel0_hi, reel1_hi, reel2_hi, reel0_z, reel1_z, reel2_z;
    logic [6:0] credits, credits_hi, credits_z;
    logic [1:0] win, win_hi, win_z;
    logic       busy, busy_hi, busy_z, done, done_hi, done_z;

    int checks = 0;
    int failures = 0;

    logic [3:0] r0_tab [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};
    logic [3:0] r1_tab [10] = '{4'd3, 4'd6, 4'd9, 4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd0};
    logic [3:0] r2_tab [10] = '{4'd7, 4'd4, 4'd1, 4'd8, 4'd5, 4'd2, 4'd9, 4'd6, 4'd3, 4'd0};

    always #5 clk = ~clk;

    slot_reel_controller #(.SPIN_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .reel0(reel0), .reel1(reel1), .reel2(reel2),
        .credits(credits), .win(win), .busy(busy), .done(done)
    );

    slot_reel_controller #(.SPIN_DIV(4), .INIT_CREDITS(95)) u_hi (
        .clk(clk), .rst_n(rst_n), .start(start_hi), .stop(stop_hi),
        .reel0(reel0_hi), .reel1(reel1_hi), .reel2(reel2_hi),
        .credits(credits_hi), .win(win_hi), .busy(busy_hi), .done(done_hi)
    );

    slot_reel_controller #(.SPIN_DIV(4), .INIT_CREDITS(0)) u_zero (
        .clk(clk), .rst_n(rst_n), .start(start_z), .stop(stop_z),
        .reel0(reel0_z), .reel1(reel1_z), .reel2(reel2_z),
        .credits(credits_z), .win(win_z), .busy(busy_z), .done(done_z)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive main-instance inputs for one rising edge, then sample 1 time unit later.
    task automatic cyc(input logic st, input logic sp);
        start = st;
        stop  = sp;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic chk_reels(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                             input logic [3:0] e2);
        chk({tag, "_reel0"}, {4'd0, reel0}, {4'd0, e0});
        chk({tag, "_reel1"}, {4'd0, reel1}, {4'd0, e1});
        chk({tag, "_reel2"}, {4'd0, reel2}, {4'd0, e2});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values while rst_n is held low
        repeat (2) @(posedge clk);
        #1;
        chk_reels("rst", 4'd0, 4'd0, 4'd0);
        chk("rst_credits", {1'b0, credits}, 8'd10);
        chk("rst_win", {6'd0, win}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_credits_hi", {1'b0, credits_hi}, 8'd95);
        chk("rst_credits_zero", {1'b0, credits_z}, 8'd0);
        rst_n = 1'b1;

        // Idle for 20 cycles: nothing moves, done never pulses
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0);
            chk("idle_done", {7'd0, done}, 8'd0);
        end
        chk_reels("idle", 4'd0, 4'd0, 4'd0);
        chk("idle_credits", {1'b0, credits}, 8'd10);
        chk("idle_busy", {7'd0, busy}, 8'd0);

        // Three back-to-back stops before any tick: triple 0,0,0
        cyc(1'b1, 1'b0);
        chk("t2_busy_rise", {7'd0, busy}, 8'd1);
        chk("t2_credit_debit", {1'b0, credits}, 8'd9);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        chk("t2_done_early", {7'd0, done}, 8'd0);
        chk("t2_busy_mid", {7'd0, busy}, 8'd1);
        chk("t2_credits_mid", {1'b0, credits}, 8'd9);
        cyc(1'b0, 1'b0);
        chk("t2_done", {7'd0, done}, 8'd1);
        chk("t2_busy_fall", {7'd0, busy}, 8'd0);
        chk("t2_win", {6'd0, win}, 8'd2);
        chk("t2_credits", {1'b0, credits}, 8'd19);
        chk_reels("t2", 4'd0, 4'd0, 4'd0);
        cyc(1'b0, 1'b1);
        chk("t2_done_single", {7'd0, done}, 8'd0);
        chk("t2_win_hold", {6'd0, win}, 8'd2);

        // Stop, stop, one tick, stop: 0,0,7 pair
        do_reset();
        cyc(1'b1, 1'b0);
        chk("t3_win_clear", {6'd0, win}, 8'd0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("t3_pre_tick_reel2", {4'd0, reel2}, 8'd0);
        cyc(1'b0, 1'b0);
        chk("t3_tick_reel2", {4'd0, reel2}, 8'd7);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("t3_done", {7'd0, done}, 8'd1);
        chk_reels("t3", 4'd0, 4'd0, 4'd7);
        chk("t3_win", {6'd0, win}, 8'd1);
        chk("t3_credits", {1'b0, credits}, 8'd11);

        // Stop landing on the first tick edge freezes reel0 at its pre-tick value
        do_reset();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk_reels("t4_no_early_tick", 4'd0, 4'd0, 4'd0);
        cyc(1'b0, 1'b1);
        chk_reels("t4_stop_on_tick", 4'd0, 4'd3, 4'd7);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("t4_done", {7'd0, done}, 8'd1);
        chk_reels("t4", 4'd0, 4'd3, 4'd7);
        chk("t4_win", {6'd0, win}, 8'd0);
        chk("t4_credits", {1'b0, credits}, 8'd9);

        // Ten ticks of free spinning
        do_reset();
        cyc(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            repeat (4) cyc(1'b0, 1'b0);
            chk_reels("t5_tick", r0_tab[k], r1_tab[k], r2_tab[k]);
        end
        chk("t5_busy", {7'd0, busy}, 8'd1);
        chk("t5_credits", {1'b0, credits}, 8'd9);

        // Reset mid-spin is immediate and does not refund
        repeat (4) cyc(1'b0, 1'b0);
        chk_reels("t6_spinning", 4'd1, 4'd3, 4'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reels("t6_async_rst", 4'd0, 4'd0, 4'd0);
        chk("t6_credits", {1'b0, credits}, 8'd10);
        chk("t6_busy", {7'd0, busy}, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Saturation: 95 - 1 + 10 caps at 99
        start_hi = 1'b1;
        @(posedge clk);
        #1;
        start_hi = 1'b0;
        chk("hi_debit", {1'b0, credits_hi}, 8'd94);
        stop_hi = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stop_hi = 1'b0;
        @(posedge clk);
        #1;
        chk("hi_done", {7'd0, done_hi}, 8'd1);
        chk("hi_win", {6'd0, win_hi}, 8'd2);
        chk("hi_credits_sat", {1'b0, credits_hi}, 8'd99);

        // Zero credits: start ignored
        start_z = 1'b1;
        @(posedge clk);
        #1;
        start_z = 1'b0;
        chk("zero_busy", {7'd0, busy_z}, 8'd0);
        chk("zero_credits", {1'b0, credits_z}, 8'd0);
        stop_z = 1'b1;
        @(posedge clk);
        #1;
        stop_z = 1'b0;
        chk("zero_busy_after", {7'd0, busy_z}, 8'd0);
        chk("zero_done", {7'd0, done_z}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
